rojobot_game_sequencer: RTL and testbench

Game-level sequencer for the two-Rojobot tank/train game. It runs the screen flow (start, map play, win screens) and holds both bots in reset when they must not move. It keeps the hit score for each player and rate-limits bullet firing per player. It sits in the 100 MHz bus domain, between the firmware/switch inputs and the Rojobot datapath: it drives the frame-select, bot-reset and bullet-launch controls, and it consumes the hit pulses coming back from the icon logic.

---
 rtl/rojobot_game_sequencer.sv | 150 +++++++++++++++
 tb/tb_rojobot_game_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rojobot_game_sequencer.sv
// Screen-flow sequencer for the two-Rojobot game: start/play/respawn/win states,
// per-player hit scores and per-player bullet rate limiting.
module rojobot_game_sequencer #(
  parameter int unsigned WIN_SCORE       = 3,
  parameter int unsigned RESPAWN_CYCLES  = 16,
  parameter int unsigned COOLDOWN_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start_btn,
  input  logic       map_sel,
  input  logic       tank_hit_i,
  input  logic       train_hit_i,
  input  logic [1:0] fire_req,
  output logic [4:0] frame,
  output logic [1:0] bot_reset,
  output logic [1:0] bullet_go,
  output logic [3:0] score_tank,
  output logic [3:0] score_train,
  output logic       game_active
);

  typedef enum logic [2:0] {
    S_START, S_PLAY, S_RESPAWN, S_TANK_WIN, S_TRAIN_WIN
  } state_t;

  localparam logic [3:0]  WIN      = 4'(WIN_SCORE);
  localparam logic [15:0] RSP_LOAD = 16'(RESPAWN_CYCLES - 1);
  localparam logic [15:0] CD_LOAD  = 16'(COOLDOWN_CYCLES);

  state_t            state_q, state_d;
  logic              start_btn_q, start_edge_q;
  logic              map_q, map_d;
  logic [3:0]        score_tank_q, score_tank_d;
  logic [3:0]        score_train_q, score_train_d;
  logic [15:0]       rsp_q, rsp_d;
  logic [1:0][15:0]  cd_q, cd_d;
  logic [1:0]        go_d;
  logic [4:0]        frame_d;
  logic [1:0]        bot_d;
  logic              active_d;
  logic              stay_play;

  always_comb begin
    state_d       = state_q;
    map_d         = map_q;
    score_tank_d  = score_tank_q;
    score_train_d = score_train_q;
    rsp_d         = rsp_q;
    case (state_q)
      S_START: begin
        if (start_edge_q) begin
          score_tank_d  = 4'd0;
          score_train_d = 4'd0;
          map_d         = map_sel;
          state_d       = S_PLAY;
        end
      end
      S_PLAY: begin
        if (train_hit_i && score_tank_q != WIN) score_tank_d = score_tank_q + 4'd1;
        if (tank_hit_i && score_train_q != WIN) score_train_d = score_train_q + 4'd1;
        // tank wins a simultaneous race to WIN_SCORE
        if (score_tank_d == WIN) begin
          state_d = S_TANK_WIN;
        end else if (score_train_d == WIN) begin
          state_d = S_TRAIN_WIN;
        end else if (tank_hit_i || train_hit_i) begin
          state_d = S_RESPAWN;
          rsp_d   = RSP_LOAD;
        end
      end
      S_RESPAWN: begin
        if (rsp_q == 16'd0) state_d = S_PLAY;
        else                rsp_d   = rsp_q - 16'd1;
      end
      S_TANK_WIN, S_TRAIN_WIN: begin
        if (start_edge_q) state_d = S_START;
      end
      default: state_d = S_START;
    endcase
  end

  // A grant on the same edge that leaves PLAY is dropped.
  always_comb begin
    stay_play = (state_q == S_PLAY) && (state_d == S_PLAY);
    go_d      = 2'b00;
    cd_d      = '0;
    for (int i = 0; i < 2; i++) begin
      if (stay_play) begin
        if (fire_req[i] && cd_q[i] == 16'd0) begin
          go_d[i] = 1'b1;
          cd_d[i] = CD_LOAD;
        end else if (cd_q[i] != 16'd0) begin
          cd_d[i] = cd_q[i] - 16'd1;
        end
      end
    end
  end

  always_comb begin
    frame_d  = 5'b00001;
    bot_d    = 2'b11;
    active_d = 1'b0;
    case (state_d)
      S_PLAY: begin
        frame_d  = map_d ? 5'b00010 : 5'b00100;
        bot_d    = 2'b00;
        active_d = 1'b1;
      end
      S_RESPAWN:   frame_d = map_d ? 5'b00010 : 5'b00100;
      S_TANK_WIN:  frame_d = 5'b01000;
      S_TRAIN_WIN: frame_d = 5'b10000;
      default:     frame_d = 5'b00001;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_START;
      start_btn_q   <= 1'b0;
      start_edge_q  <= 1'b0;
      map_q         <= 1'b0;
      score_tank_q  <= 4'd0;
      score_train_q <= 4'd0;
      rsp_q         <= 16'd0;
      cd_q          <= '0;
      bullet_go     <= 2'b00;
      frame         <= 5'b00001;
      bot_reset     <= 2'b11;
      game_active   <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_btn_q   <= start_btn;
      start_edge_q  <= start_btn & ~start_btn_q;
      map_q         <= map_d;
      score_tank_q  <= score_tank_d;
      score_train_q <= score_train_d;
      rsp_q         <= rsp_d;
      cd_q          <= cd_d;
      bullet_go     <= go_d;
      frame         <= frame_d;
      bot_reset     <= bot_d;
      game_active   <= active_d;
    end
  end

  assign score_tank  = score_tank_q;
  assign score_train = score_train_q;

endmodule

// File: tb/tb_rojobot_game_sequencer.sv
// Directed bench for rojobot_game_sequencer: screen flow, scoring, respawn,
// bullet cooldown and asynchronous reset.
module tb_rojobot_game_sequencer;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start_btn, map_sel, tank_hit_i, train_hit_i;
  logic [1:0] fire_req;
  logic [4:0] frame;
  logic [1:0] bot_reset, bullet_go;
  logic [3:0] score_tank, score_train;
  logic       game_active;

  int errors = 0;
  int checks = 0;

  rojobot_game_sequencer #(.WIN_SCORE(3), .RESPAWN_CYCLES(16), .COOLDOWN_CYCLES(8)) dut (
    .clk(clk), .rstn(rstn), .start_btn(start_btn), .map_sel(map_sel),
    .tank_hit_i(tank_hit_i), .train_hit_i(train_hit_i), .fire_req(fire_req),
    .frame(frame), .bot_reset(bot_reset), .bullet_go(bullet_go),
    .score_tank(score_tank), .score_train(score_train), .game_active(game_active)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; start_btn = 1'b0; map_sel = 1'b0;
    tank_hit_i = 1'b0; train_hit_i = 1'b0; fire_req = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (frame !== 5'b00001 || bot_reset !== 2'b11 || bullet_go !== 2'b00 ||
        score_tank !== 4'd0 || score_train !== 4'd0 || game_active !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: frame=%b bot=%b go=%b st=%0d sr=%0d act=%b", frame, bot_reset,
               bullet_go, score_tank, score_train, game_active);
    end
    for (int c = 0; c < 20; c++) begin
      step();
      checks++;
      if (frame !== 5'b00001 || bot_reset !== 2'b11 || bullet_go !== 2'b00 ||
          score_tank !== 4'd0 || score_train !== 4'd0) begin
        errors++;
        $display("FAIL idle_start cycle %0d: frame=%b bot=%b go=%b want 00001/11/00", c, frame,
                 bot_reset, bullet_go);
      end
    end
  endtask

  task automatic test_start_map(input logic m, input logic [4:0] exp_frame);
    map_sel = m;
    start_btn = 1'b1;
    step();
    checks++;
    if (frame !== 5'b00001 || bot_reset !== 2'b11) begin
      errors++;
      $display("FAIL start_early map%0d: frame=%b bot=%b want 00001/11", m, frame, bot_reset);
    end
    step();
    checks++;
    if (frame !== exp_frame || bot_reset !== 2'b00 || game_active !== 1'b1) begin
      errors++;
      $display("FAIL start_play map%0d: frame=%b bot=%b act=%b want %b/00/1", m, frame, bot_reset,
               game_active, exp_frame);
    end
    start_btn = 1'b0;
  endtask

  task automatic test_hit_respawn();
    train_hit_i = 1'b1;
    step();
    train_hit_i = 1'b0;
    checks++;
    if (score_tank !== 4'd1 || bot_reset !== 2'b11 || frame !== 5'b00100 || game_active !== 1'b0) begin
      errors++;
      $display("FAIL hit_score: st=%0d bot=%b frame=%b act=%b want 1/11/00100/0", score_tank,
               bot_reset, frame, game_active);
    end
    for (int c = 2; c <= 16; c++) begin
      if (c == 5) tank_hit_i = 1'b1;
      step();
      tank_hit_i = 1'b0;
      checks++;
      if (bot_reset !== 2'b11 || frame !== 5'b00100) begin
        errors++;
        $display("FAIL respawn_hold cycle %0d: bot=%b frame=%b want 11/00100", c, bot_reset, frame);
      end
    end
    step();
    checks++;
    if (bot_reset !== 2'b00 || frame !== 5'b00100 || game_active !== 1'b1 || score_train !== 4'd0) begin
      errors++;
      $display("FAIL respawn_end: bot=%b frame=%b act=%b sr=%0d want 00/00100/1/0", bot_reset,
               frame, game_active, score_train);
    end
  endtask

  task automatic hit_and_wait(input logic t, input logic r);
    tank_hit_i = t; train_hit_i = r;
    step();
    tank_hit_i = 1'b0; train_hit_i = 1'b0;
    repeat (16) step();
  endtask

  task automatic test_win();
    hit_and_wait(1'b0, 1'b1);
    hit_and_wait(1'b1, 1'b0);
    hit_and_wait(1'b1, 1'b0);
    checks++;
    if (score_tank !== 4'd2 || score_train !== 4'd2 || game_active !== 1'b1) begin
      errors++;
      $display("FAIL pre_win: st=%0d sr=%0d act=%b want 2/2/1", score_tank, score_train, game_active);
    end
    tank_hit_i = 1'b1; train_hit_i = 1'b1;
    step();
    tank_hit_i = 1'b0; train_hit_i = 1'b0;
    checks++;
    if (score_tank !== 4'd3 || score_train !== 4'd3 || frame !== 5'b01000 || bot_reset !== 2'b11) begin
      errors++;
      $display("FAIL tank_win: st=%0d sr=%0d frame=%b bot=%b want 3/3/01000/11", score_tank,
               score_train, frame, bot_reset);
    end
    map_sel = 1'b1;
    start_btn = 1'b1;
    step(); step();
    checks++;
    if (frame !== 5'b00001 || score_tank !== 4'd3 || score_train !== 4'd3) begin
      errors++;
      $display("FAIL win_to_start: frame=%b st=%0d sr=%0d want 00001/3/3", frame, score_tank, score_train);
    end
    start_btn = 1'b0;
    step();
    start_btn = 1'b1;
    step(); step();
    start_btn = 1'b0;
    checks++;
    if (frame !== 5'b00010 || score_tank !== 4'd0 || score_train !== 4'd0 || bot_reset !== 2'b00) begin
      errors++;
      $display("FAIL restart_clear: frame=%b st=%0d sr=%0d bot=%b want 00010/0/0/00", frame,
               score_tank, score_train, bot_reset);
    end
  endtask

  task automatic test_fire();
    logic [1:0] exp;
    for (int k = 1; k <= 45; k++) begin
      fire_req = (k <= 30) ? 2'b11 : 2'b01;
      step();
      exp = 2'b00;
      if ((k - 1) % 9 == 0) exp = (k <= 30) ? 2'b11 : 2'b01;
      checks++;
      if (bullet_go !== exp) begin
        errors++;
        $display("FAIL fire_cadence k=%0d: bullet_go=%b want %b", k, bullet_go, exp);
      end
    end
    fire_req = 2'b00;
    repeat (10) step();
  endtask

  task automatic test_back_to_back();
    fire_req = 2'b01;
    train_hit_i = 1'b1;
    step();
    fire_req = 2'b00;
    train_hit_i = 1'b0;
    checks++;
    if (bullet_go !== 2'b00 || score_tank !== 4'd1 || bot_reset !== 2'b11) begin
      errors++;
      $display("FAIL grant_drop: go=%b st=%0d bot=%b want 00/1/11", bullet_go, score_tank, bot_reset);
    end
  endtask

  task automatic test_async_reset();
    repeat (3) step();
    fire_req = 2'b11;
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (frame !== 5'b00001 || bot_reset !== 2'b11 || bullet_go !== 2'b00 ||
        score_tank !== 4'd0 || score_train !== 4'd0 || game_active !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: frame=%b bot=%b go=%b st=%0d sr=%0d act=%b", frame, bot_reset,
               bullet_go, score_tank, score_train, game_active);
    end
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (bullet_go !== 2'b00 || frame !== 5'b00001 || bot_reset !== 2'b11) begin
        errors++;
        $display("FAIL post_reset cycle %0d: go=%b frame=%b bot=%b want 00/00001/11", c,
                 bullet_go, frame, bot_reset);
      end
    end
    fire_req = 2'b00;
  endtask

  initial begin
    test_reset();
    test_start_map(1'b1, 5'b00010);
    do_reset();
    test_start_map(1'b0, 5'b00100);
    test_hit_respawn();
    test_win();
    test_fire();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
